// File: rtl/battleship_board.sv
// battleship_board
//   One player's board for the Battleship game. Ship cells are placed on LDR1
//   rising edges. Shots are fired on LDR2 rising edges and each one is
//   resolved in a single EVAL cycle. OK and Liv report back to the game FSM.
// Ports
//   clk, clr_n     clock, async active-low reset
//   LDR1/LDR2      place / fire requests (edge-triggered, sampled on clk)
//   Disp           led enable
//   coord          cell index for the current placement or shot
//   OK             fleet placed and last shot accepted
//   Liv            fleet still has an unhit ship cell
//   hit/miss/dup   one-cycle result pulses
//   hits           distinct ship cells hit
//   led            ship_map while placing, shot_map afterwards, 0 when !Disp
module battleship_board #(
  parameter int CELLS = 16,
  parameter int SHIPS = 3
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     LDR1,
  input  logic                     LDR2,
  input  logic                     Disp,
  input  logic [$clog2(CELLS)-1:0] coord,
  output logic                     OK,
  output logic                     Liv,
  output logic                     hit,
  output logic                     miss,
  output logic                     dup,
  output logic [3:0]               hits,
  output logic [CELLS-1:0]         led
);
  localparam int AW = $clog2(CELLS);
  localparam int CW = $clog2(SHIPS + 1);

  typedef enum logic [1:0] {PLACE, ARMED, EVAL, DEAD} state_t;

  state_t           state, state_nxt;
  logic [CELLS-1:0] ship_map, shot_map;
  logic [CW-1:0]    ship_cnt, hit_cnt;
  logic [AW-1:0]    shot_reg;
  logic             ldr1_q, ldr2_q;
  logic             rise1, rise2;
  logic             last_ship, shot_new, shot_on_ship, last_hit;

  assign rise1        = LDR1 & ~ldr1_q;
  assign rise2        = LDR2 & ~ldr2_q;
  assign last_ship    = (ship_cnt + CW'(1)) == CW'(SHIPS);
  assign shot_new     = ~shot_map[shot_reg];
  assign shot_on_ship = ship_map[shot_reg];
  assign last_hit     = (hit_cnt + CW'(1)) == CW'(SHIPS);

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= PLACE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      PLACE: if (rise1 && !ship_map[coord] && last_ship) state_nxt = ARMED;
      ARMED: if (rise2) state_nxt = EVAL;
      EVAL:  state_nxt = (shot_new && shot_on_ship && last_hit) ? DEAD : ARMED;
      DEAD:  state_nxt = DEAD;
      default: state_nxt = PLACE;
    endcase
  end

  // Board registers and result pulses. The pulses default low each cycle,
  // so DEAD naturally holds them at zero.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ship_map <= '0;
      shot_map <= '0;
      ship_cnt <= '0;
      hit_cnt  <= '0;
      shot_reg <= '0;
      ldr1_q   <= 1'b0;
      ldr2_q   <= 1'b0;
      OK       <= 1'b0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      dup      <= 1'b0;
    end else begin
      ldr1_q <= LDR1;
      ldr2_q <= LDR2;
      hit    <= 1'b0;
      miss   <= 1'b0;
      dup    <= 1'b0;
      case (state)
        PLACE: if (rise1) begin
          if (ship_map[coord]) dup <= 1'b1;
          else begin
            ship_map[coord] <= 1'b1;
            ship_cnt        <= ship_cnt + CW'(1);
            if (last_ship) OK <= 1'b1;
          end
        end
        ARMED: if (rise2) shot_reg <= coord;
        EVAL: begin
          if (shot_new) begin
            shot_map[shot_reg] <= 1'b1;
            OK                 <= 1'b1;
            if (shot_on_ship) begin
              hit_cnt <= hit_cnt + CW'(1);
              hit     <= 1'b1;
            end else begin
              miss <= 1'b1;
            end
          end else begin
            // Repeat shot: dropping OK tells the FSM to ask for another shot
            dup <= 1'b1;
            OK  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Combinational outputs
  always_comb begin
    Liv  = hit_cnt != CW'(SHIPS);
    hits = 4'(hit_cnt);
    led  = '0;
    if (Disp) led = (state == PLACE) ? ship_map : shot_map;
  end
endmodule

// File: tb/tb_battleship_board.sv
module tb_battleship_board;
  localparam int CELLS = 16;
  localparam int SHIPS = 3;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        LDR1 = 1'b0, LDR2 = 1'b0, Disp = 1'b1;
  logic [3:0]  coord = '0;
  logic        OK, Liv, hit, miss, dup;
  logic [3:0]  hits;
  logic [15:0] led;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: sets of placed and shot cells plus expected pulses
  bit ship [CELLS];
  bit shot [CELLS];
  int n_ship, n_hit;
  bit e_ok, e_hit, e_miss, e_dup;

  battleship_board #(.CELLS(CELLS), .SHIPS(SHIPS)) dut (
    .clk(clk), .clr_n(clr_n), .LDR1(LDR1), .LDR2(LDR2), .Disp(Disp),
    .coord(coord), .OK(OK), .Liv(Liv), .hit(hit), .miss(miss), .dup(dup),
    .hits(hits), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mask_of(input bit m [CELLS]);
    logic [15:0] r = '0;
    for (int i = 0; i < CELLS; i++) if (m[i]) r[i] = 1'b1;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) begin ship[i] = 0; shot[i] = 0; end
    n_ship = 0; n_hit = 0;
    e_ok = 0; e_hit = 0; e_miss = 0; e_dup = 0;
  endtask

  task automatic check_all(input string tag);
    logic [15:0] e_led;
    e_led = !Disp ? 16'h0 : (n_ship < SHIPS) ? mask_of(ship) : mask_of(shot);
    chk({tag, "_led"},  32'(led),  32'(e_led));
    chk({tag, "_ok"},   32'(OK),   32'(e_ok));
    chk({tag, "_liv"},  32'(Liv),  32'(n_hit != SHIPS));
    chk({tag, "_hit"},  32'(hit),  32'(e_hit));
    chk({tag, "_miss"}, 32'(miss), 32'(e_miss));
    chk({tag, "_dup"},  32'(dup),  32'(e_dup));
    chk({tag, "_hits"}, 32'(hits), 32'(n_hit));
  endtask

  task automatic quiet_pulses();
    e_hit = 0; e_miss = 0; e_dup = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    clr_n = 1'b0; LDR1 = 1'b0; LDR2 = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  // Placement: rise sampled at edge n, effect visible after edge n
  task automatic place(input string tag, input int c);
    quiet_pulses();
    if (n_ship < SHIPS) begin
      if (ship[c]) e_dup = 1;
      else begin
        ship[c] = 1; n_ship++;
        if (n_ship == SHIPS) e_ok = 1;
      end
    end
    coord = 4'(c); LDR1 = 1'b1;
    @(posedge clk); @(negedge clk);
    check_all(tag);
    LDR1 = 1'b0;
    quiet_pulses();
    @(posedge clk); @(negedge clk);
    check_all({tag, "_q"});
  endtask

  // Shot: rise at edge k enters EVAL, results after edge k+1.
  // LDR2 is held for 'hold' cycles to exercise the edge detector.
  task automatic fire(input string tag, input int c, input int hold);
    quiet_pulses();
    if (n_ship == SHIPS && n_hit < SHIPS) begin
      if (shot[c]) begin e_dup = 1; e_ok = 0; end
      else begin
        shot[c] = 1; e_ok = 1;
        if (ship[c]) begin n_hit++; e_hit = 1; end
        else e_miss = 1;
      end
    end
    coord = 4'(c); LDR2 = 1'b1;
    @(posedge clk); @(negedge clk);
    if (hold <= 1) LDR2 = 1'b0;
    @(posedge clk); @(negedge clk);
    check_all(tag);
    quiet_pulses();
    for (int i = 2; i < hold; i++) begin @(posedge clk); @(negedge clk); end
    LDR2 = 1'b0;
    @(posedge clk); @(negedge clk);
    check_all({tag, "_q"});
  endtask

  initial begin
    model_clear();
    #12;
    check_all("rst_init");
    @(negedge clk); clr_n = 1'b1;

    // Fleet at 0, 5, 15
    place("p0", 0); place("p5", 5); place("p15", 15);
    Disp = 1'b0; #1; check_all("disp_off"); Disp = 1'b1;

    // Duplicate placement
    do_reset("rst_dup");
    place("d5a", 5); place("d5b", 5);
    fire("fire_in_place", 3, 1);
    place("d0", 0); place("d15", 15);

    // Shots: hit, miss, repeat, hit, final hit
    fire("f5", 5, 1); fire("f6", 6, 1); fire("f5r", 5, 1);
    fire("f0", 0, 1); fire("f15", 15, 1);
    // DEAD: everything ignored
    place("dead_p", 3); fire("dead_f", 4, 1);

    // Held LDR2 evaluates once
    do_reset("rst_hold");
    place("h1", 1); place("h2", 2); place("h3", 3);
    fire("hold10", 2, 10);
    fire("after_hold", 7, 1);

    // Reset in the middle of EVAL
    coord = 4'd1; LDR2 = 1'b1;
    @(posedge clk); #2;
    clr_n = 1'b0; LDR2 = 1'b0;
    #1; model_clear();
    check_all("rst_eval");
    @(negedge clk); clr_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check_all("post_rst_eval");

    // Randomized games against the model
    for (int g = 0; g < 6; g++) begin
      do_reset("rnd_rst");
      for (int s = 0; s < 45; s++) begin
        Disp = 1'($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) == 0 || n_ship < SHIPS)
          place("rnd_p", int'($urandom_range(0, CELLS - 1)));
        else
          fire("rnd_f", int'($urandom_range(0, CELLS - 1)), int'($urandom_range(1, 3)));
      end
      Disp = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
